ascii_number_receiver: RTL and testbench
========================================

# ascii_number_receiver

Receive-side counterpart of the game's message transmitter. Pops ASCII characters from the UART receive FIFO, accumulates a decimal number terminated by CR or LF, and presents it to the game logic as a binary value with a one-cycle valid strobe. Malformed, oversized or over-long entries raise a one-cycle error strobe instead. Sits between the `uart` receiver port and the game FSM.

## Interface
- `WIDTH`, 8, width of the reported value; the maximum legal value is 2^WIDTH-1.
- `MAX_DIGITS`, 3, maximum number of digits accepted per entry.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- One clock; reset is asynchronous and active-low.
- `r_data` in 8: head of the UART RX FIFO, first-word-fall-through; valid while `rx_empty`=0.
- `rx_empty` in 1: RX FIFO empty.
- `rd_uart` out 1: pop strobe to the RX FIFO.
- `enable` in 1: when high, characters are consumed.
- `clear` in 1: synchronous abort of the partial entry.
- `value` out WIDTH: last successfully parsed number; held until the next success.
- `value_valid` out 1: one-cycle pulse when `value` updates.
- `error` out 1: one-cycle pulse on a rejected entry.
- `digit_count` out clog2(MAX_DIGITS+1): number of digits in the current partial entry.

## Operation
- There are two states, IDLE and DECODE.
- **IDLE:** if `enable`=1, `clear`=0 and `rx_empty`=0:
  - latch `r_data` into `char`;
  - drive `rd_uart`=1 combinationally in this cycle;
  - go to DECODE.
  - Otherwise stay in IDLE with `rd_uart`=0.
- **DECODE** classifies `char`, then always returns to IDLE.
- Digit `0x30`–`0x39`:
  - If `digit_count` < MAX_DIGITS, set acc <= acc*10 + (char-0x30) and increment `digit_count`.
  - If the new acc exceeds 2^WIDTH-1, set the sticky `ovf` flag and hold acc at 2^WIDTH-1.
  - If `digit_count` = MAX_DIGITS, set `ovf`; acc and count are unchanged.
- CR `0x0D` or LF `0x0A`:
  - If `digit_count`=0 and `bad`=0, ignore the character; no strobe.
  - Else if `ovf` or `bad` is set, register `error`<=1.
  - Else register `value`<=acc and `value_valid`<=1.
  - In all three cases, clear acc, `digit_count`, `ovf` and `bad`.
- Any other byte sets the sticky `bad` flag. Parsing continues to the terminator, so one error is reported per line.
- `clear`=1, in any state: clear acc, count and flags; go to IDLE; no pop in that cycle. A `clear` in DECODE discards that character.
- `enable`=0 does not clear the partial entry; it only stalls consumption.
- The internal accumulator is WIDTH+4 bits so the overflow compare is exact.

## Timing
- Reset values:
  - state IDLE;
  - `rd_uart`=0, `value`=0, `value_valid`=0, `error`=0, `digit_count`=0;
  - acc, `ovf`, `bad` and `char` all 0.
- The character is popped at cycle T (`rd_uart`=1) and decoded at T+1.
- `value`, `value_valid` and `error` are registered. After a terminator popped at T they are visible in cycle T+2, for exactly one cycle.
- Throughput is one character per 2 cycles. `rd_uart` is never high in two consecutive cycles.
- `value_valid` and `error` are never high together.
- Reset mid-entry discards the partial entry immediately. The next character starts a new entry.

## Configuration
- `ASCII_RX_ECHO_EN` defined:
  - adds input `echo_full` (1 bit, from UART `tx_full`);
  - adds output `echo_data` (8 bits, = `char`);
  - adds output `echo_wr` (1 bit).
  - `echo_wr`=1 in every DECODE cycle where `echo_full`=0 and `clear`=0, so typed characters are echoed on the transmit path.
  - While `echo_full`=1 the echo is dropped, not stalled.
- `ASCII_RX_ECHO_EN` undefined: these ports and this logic are absent. Parsing behaviour is identical.

## Test plan
- Feed "42\r" with `enable`=1 → three pops two cycles apart; `value`=42 and `value_valid` pulse at T+2 after the CR pop; `error` stays 0.
- WIDTH=8: "256\n" → `error` pulse, `value` unchanged. "255\n" → `value`=255 with a valid pulse.
- "1a3\r" → one `error` pulse. "1234\r" with MAX_DIGITS=3 → one `error` pulse. A lone "\r" → no strobe and `digit_count` stays 0.
- `enable`=0 with a non-empty FIFO for 20 cycles → `rd_uart` stays 0. Then "7\r" with `enable`=1 → `value`=7.
- Send "4", then either assert `reset_n`=0 or pulse `clear`, then send "9\r" → `value`=9. After reset, all outputs read 0 before the "9".
- With `ASCII_RX_ECHO_EN`: "5\r" → `echo_wr` pulses with `echo_data`=0x35, then 0x0D, each in its DECODE cycle. With `echo_full`=1 → no `echo_wr`, and `value`=5 is still reported.

Source files
------------

// File: rtl/ascii_number_receiver.sv
// ASCII decimal line receiver: pops characters from a FWFT RX FIFO and reports the
// value or an error when CR/LF ends the line. Optional echo path: ASCII_RX_ECHO_EN.
module ascii_number_receiver #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [7:0]                           r_data,
    input  logic                                 rx_empty,
    output logic                                 rd_uart,
    input  logic                                 enable,
    input  logic                                 clear,
    output logic [WIDTH-1:0]                     value,
    output logic                                 value_valid,
    output logic                                 error,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      digit_count
`ifdef ASCII_RX_ECHO_EN
    ,
    input  logic                                 echo_full,
    output logic [7:0]                           echo_data,
    output logic                                 echo_wr
`endif
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int AW = WIDTH + 4;
    localparam logic [AW-1:0] MAX_VAL = {4'b0000, {WIDTH{1'b1}}};

    typedef enum logic {IDLE, DECODE} state_t;

    state_t          state, state_n;
    logic [7:0]      char_q, char_n;
    logic [AW-1:0]   acc, acc_n, sum;
    logic [CW-1:0]   cnt_n;
    logic            ovf, ovf_n, bad, bad_n;
    logic [WIDTH-1:0] value_n;
    logic            value_valid_n, error_n;
    logic            is_digit, is_term;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            char_q      <= '0;
            acc         <= '0;
            digit_count <= '0;
            ovf         <= 1'b0;
            bad         <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            char_q      <= char_n;
            acc         <= acc_n;
            digit_count <= cnt_n;
            ovf         <= ovf_n;
            bad         <= bad_n;
            value       <= value_n;
            value_valid <= value_valid_n;
            error       <= error_n;
        end
    end

    assign is_digit = (char_q >= 8'h30) && (char_q <= 8'h39);
    assign is_term  = (char_q == 8'h0D) || (char_q == 8'h0A);
    // acc never exceeds MAX_VAL, so the product cannot wrap in WIDTH+4 bits
    assign sum      = acc * AW'(10) + AW'(char_q - 8'h30);

    always_comb begin
        state_n       = state;
        rd_uart       = 1'b0;
        char_n        = char_q;
        acc_n         = acc;
        cnt_n         = digit_count;
        ovf_n         = ovf;
        bad_n         = bad;
        value_n       = value;
        value_valid_n = 1'b0;
        error_n       = 1'b0;
        if (clear) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
            bad_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !rx_empty) begin
                        char_n  = r_data;
                        rd_uart = 1'b1;
                        state_n = DECODE;
                    end
                end
                DECODE: begin
                    state_n = IDLE;
                    if (is_digit) begin
                        if (digit_count < CW'(MAX_DIGITS)) begin
                            cnt_n = digit_count + CW'(1);
                            if (sum > MAX_VAL) begin
                                ovf_n = 1'b1;
                                acc_n = MAX_VAL;
                            end else begin
                                acc_n = sum;
                            end
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end else if (is_term) begin
                        // empty line with no junk is silently ignored
                        if (digit_count != '0 || bad) begin
                            if (ovf || bad) begin
                                error_n = 1'b1;
                            end else begin
                                value_n       = acc[WIDTH-1:0];
                                value_valid_n = 1'b1;
                            end
                        end
                        acc_n = '0;
                        cnt_n = '0;
                        ovf_n = 1'b0;
                        bad_n = 1'b0;
                    end else begin
                        bad_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef ASCII_RX_ECHO_EN
    // echo is best effort: a full TX FIFO drops the byte rather than stalling parsing
    assign echo_data = char_q;
    assign echo_wr   = (state == DECODE) && !echo_full && !clear;
`endif

endmodule

// File: tb/tb_ascii_number_receiver.sv
// Self-checking bench for ascii_number_receiver: vector table, corner sequences and
// random lines checked against a line-level reference model.
module tb_ascii_number_receiver;
    localparam int WIDTH      = 8;
    localparam int MAX_DIGITS = 3;

    logic        clk, reset_n;
    logic [7:0]  r_data;
    logic        rx_empty, rd_uart, enable, clear;
    logic [WIDTH-1:0] value;
    logic        value_valid, error;
    logic [1:0]  digit_count;
`ifdef ASCII_RX_ECHO_EN
    logic        echo_full, echo_wr;
    logic [7:0]  echo_data;
`endif

    ascii_number_receiver #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
        .clk(clk), .reset_n(reset_n), .r_data(r_data), .rx_empty(rx_empty),
        .rd_uart(rd_uart), .enable(enable), .clear(clear), .value(value),
        .value_valid(value_valid), .error(error), .digit_count(digit_count)
`ifdef ASCII_RX_ECHO_EN
        , .echo_full(echo_full), .echo_data(echo_data), .echo_wr(echo_wr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string s;
        int    ev;   // 0 none, 1 value, 2 error
        int    v;
    } vec_t;

    byte unsigned fifo[$];
    byte unsigned echo_q[$];
    int  n_checks = 0, n_fail = 0;
    int  it = 0, n_val, n_err, n_pops, dbl_pop, both, pop_it, val_it;
    bit  prev_pop = 0, rand_en = 0;
    int  exp_value = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        bit pop;
        it++;
        if (rand_en) enable = ($urandom_range(0, 9) != 0);
        rx_empty = (fifo.size() == 0);
        r_data   = rx_empty ? 8'h00 : fifo[0];
        #1;
        pop = rd_uart;
`ifdef ASCII_RX_ECHO_EN
        if (echo_wr) echo_q.push_back(echo_data);
`endif
        if (pop) begin n_pops++; pop_it = it; end
        if (pop && prev_pop) dbl_pop++;
        prev_pop = pop;
        @(posedge clk);
        if (pop) void'(fifo.pop_front());
        #1;
        if (value_valid && error) both++;
        if (value_valid) begin n_val++; val_it = it; end
        if (error) n_err++;
    endtask

    // Push a line, drain the FIFO, then let the pipeline settle.
    task automatic run_line(input string s);
        int k;
        n_val = 0; n_err = 0; n_pops = 0; dbl_pop = 0; both = 0;
        for (int i = 0; i < s.len(); i++) fifo.push_back(s[i]);
        k = 0;
        while (fifo.size() != 0 && k < 400) begin cycle(); k++; end
        if (fifo.size() != 0) begin
            check("drain_timeout", fifo.size(), 0);
            fifo.delete();
        end
        for (int i = 0; i < 4; i++) cycle();
    endtask

    // Line-level model: evaluates the whole line text with plain integer arithmetic.
    function automatic void ref_line(input string s, output int ev, output int v);
        int nd = 0;
        bit junk = 0;
        longint num = 0;
        for (int i = 0; i < s.len() - 1; i++) begin
            if (s[i] >= "0" && s[i] <= "9") begin
                nd++;
                if (nd <= MAX_DIGITS) num = num * 10 + (s[i] - "0");
            end else junk = 1;
        end
        v = int'(num);
        if (nd == 0 && !junk) ev = 0;
        else if (junk || nd > MAX_DIGITS || num > (2 ** WIDTH - 1)) ev = 2;
        else ev = 1;
    endfunction

    task automatic check_line(input string name, input int ev, input int v);
        check({name, "_valid"}, n_val, (ev == 1) ? 1 : 0);
        check({name, "_error"}, n_err, (ev == 2) ? 1 : 0);
        if (ev == 1) exp_value = v;
        check({name, "_value"}, int'(value), exp_value);
        check({name, "_rules"}, dbl_pop + both, 0);
    endtask

    vec_t vecs[11];

    initial begin
        int ev, v, len;
        string s;
        byte unsigned c;

        vecs[0]  = '{"42\015",    1, 42};
        vecs[1]  = '{"256\012",   2, 0};
        vecs[2]  = '{"255\012",   1, 255};
        vecs[3]  = '{"1a3\015",   2, 0};
        vecs[4]  = '{"1234\015",  2, 0};
        vecs[5]  = '{"\015",      0, 0};
        vecs[6]  = '{"0\012",     1, 0};
        vecs[7]  = '{"007\015",   1, 7};
        vecs[8]  = '{"x\012",     2, 0};
        vecs[9]  = '{"999\015",   2, 0};
        vecs[10] = '{"10\012",    1, 10};

        reset_n = 1'b0; enable = 1'b1; clear = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
`ifdef ASCII_RX_ECHO_EN
        echo_full = 1'b0;
`endif
        #22;
        check("reset_value", int'(value), 0);
        check("reset_strobes", {30'd0, value_valid, error}, 0);
        check("reset_digit_count", int'(digit_count), 0);
        check("reset_rd_uart", int'(rd_uart), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // "42\r": pops two cycles apart, strobe two cycles after the CR pop
        run_line(vecs[0].s);
        check("latency_42", val_it, pop_it + 1);
        check("pops_42", n_pops, 3);
        check_line("v42", 1, 42);

        for (int i = 1; i < 11; i++) begin
            run_line(vecs[i].s);
            check_line($sformatf("vec%0d", i), vecs[i].ev, vecs[i].v);
            check($sformatf("vec%0d_count", i), int'(digit_count), 0);
        end

        // enable low stalls consumption without touching the FIFO
        enable = 1'b0;
        fifo.push_back(8'h37); fifo.push_back(8'h0D);
        n_pops = 0;
        for (int i = 0; i < 20; i++) cycle();
        check("stall_pops", n_pops, 0);
        check("stall_fifo", fifo.size(), 2);
        enable = 1'b1;
        run_line("");
        check_line("after_stall", 1, 7);

        // clear drops a partial entry
        run_line("4");
        check("partial_count", int'(digit_count), 1);
        clear = 1'b1; cycle(); clear = 1'b0;
        check("clear_count", int'(digit_count), 0);
        run_line("9\015");
        check_line("after_clear", 1, 9);

        // clear during DECODE discards the just-popped character
        fifo.push_back(8'h35);
        n_pops = 0;
        for (int i = 0; i < 10 && n_pops == 0; i++) cycle();
        clear = 1'b1; cycle(); clear = 1'b0;
        check("clear_decode_count", int'(digit_count), 0);
        run_line("\015");
        check_line("clear_decode_cr", 0, 0);
        run_line("3\015");
        check_line("clear_decode_3", 1, 3);

        // asynchronous reset mid-entry
        run_line("4");
        reset_n = 1'b0;
        #2;
        check("midreset_value", int'(value), 0);
        check("midreset_strobes", {30'd0, value_valid, error}, 0);
        check("midreset_count", int'(digit_count), 0);
        check("midreset_rd_uart", int'(rd_uart), 0);
        exp_value = 0;
        @(posedge clk); #3; reset_n = 1'b1;
        @(posedge clk); #1;
        run_line("9\015");
        check_line("after_reset", 1, 9);

`ifdef ASCII_RX_ECHO_EN
        echo_full = 1'b1; echo_q.delete();
        run_line("5\015");
        check("echo_full_drop", echo_q.size(), 0);
        check_line("echo_full_value", 1, 5);
        echo_full = 1'b0; echo_q.delete();
        run_line("5\015");
        check("echo_count", echo_q.size(), 2);
        if (echo_q.size() == 2) begin
            check("echo_byte0", int'(echo_q[0]), 8'h35);
            check("echo_byte1", int'(echo_q[1]), 8'h0D);
        end
        check_line("echo_value", 1, 5);
`endif

        // random lines with random enable gaps
        rand_en = 1;
        for (int n = 0; n < 150; n++) begin
            s = "";
            len = $urandom_range(0, 5);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) < 8) c = 8'($urandom_range(8'h30, 8'h39));
                else if ($urandom_range(0, 1) == 1) c = 8'($urandom_range(8'h3A, 8'hFF));
                else c = 8'($urandom_range(8'h20, 8'h2F));
                s = $sformatf("%s%c", s, c);
            end
            s = $sformatf("%s%c", s, ($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
            ref_line(s, ev, v);
            run_line(s);
            check_line($sformatf("rand%0d", n), ev, v);
        end
        rand_en = 0;
        enable = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
